// File: rtl/minmax_scan_tracker.sv
// minmax_scan_tracker: tracks the minimum or maximum word (with its address) across one scan of beats.
// Ports:
//   clk, rst_n              clock, asynchronous active-low reset
//   start, mode             begin a scan; mode 0 = minimum, 1 = maximum (latched at start)
//   in_valid/in_data/in_addr/in_last   scan beat stream, accepted when in_valid && in_ready
//   in_ready, busy, done    registered handshake/status (done is a one-cycle pulse)
//   best_valid/best_data/best_addr     current extreme word and its address
//   beat_count              accepted beats in the current or last scan, saturating
module minmax_scan_tracker #(
    parameter int DATA_W   = 8,
    parameter int ADDR_W   = 8,
    parameter int TIE_LAST = 0
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              start,
    input  logic              mode,
    input  logic              in_valid,
    input  logic [DATA_W-1:0] in_data,
    input  logic [ADDR_W-1:0] in_addr,
    input  logic              in_last,
    output logic              in_ready,
    output logic              busy,
    output logic              done,
    output logic              best_valid,
    output logic [DATA_W-1:0] best_data,
    output logic [ADDR_W-1:0] best_addr,
    output logic [ADDR_W:0]   beat_count
);
    typedef enum logic [1:0] {IDLE, SCAN, DONE} state_t;

    localparam logic [ADDR_W:0] CNT_MAX = '1;

    state_t state;
    logic   mode_q;
    logic   take;

    // First beat of a scan always loads; later beats load on a strict win, or on a tie if TIE_LAST.
    always_comb begin
        take = !best_valid
            || (mode_q ? (in_data > best_data) : (in_data < best_data))
            || ((TIE_LAST != 0) && (in_data == best_data));
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state      <= IDLE;
            mode_q     <= 1'b0;
            in_ready   <= 1'b0;
            busy       <= 1'b0;
            done       <= 1'b0;
            best_valid <= 1'b0;
            best_data  <= '0;
            best_addr  <= '0;
            beat_count <= '0;
        end else begin
            case (state)
                IDLE: if (start) begin
                    state      <= SCAN;
                    mode_q     <= mode;
                    beat_count <= '0;
                    best_valid <= 1'b0;
                    in_ready   <= 1'b1;
                    busy       <= 1'b1;
                end
                SCAN: if (in_valid) begin
                    beat_count <= (beat_count == CNT_MAX) ? beat_count : beat_count + 1'b1;
                    if (take) begin
                        best_data  <= in_data;
                        best_addr  <= in_addr;
                        best_valid <= 1'b1;
                    end
                    if (in_last) begin
                        state    <= DONE;
                        done     <= 1'b1;
                        busy     <= 1'b0;
                        in_ready <= 1'b0;
                    end
                end
                DONE: begin
                    state <= IDLE;
                    done  <= 1'b0;
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule

// File: doc/minmax_scan_tracker.md
MINMAX_SCAN_TRACKER -- requirements
Module: minmax_scan_tracker

Interface
REQ-001 Parameter DATA_W, default 8, width of each scanned data word.
REQ-002 Parameter ADDR_W, default 8, width of each scanned address.
REQ-003 Parameter TIE_LAST, default 0, tie rule: 0 keeps the earliest equal word, 1 keeps the latest.
REQ-004 Clk  input  1  single clock; all state updates on its rising edge.
REQ-005 Rst_n  input  1  reset, asynchronous, active-low.
REQ-006 Start  input  1  one-cycle pulse that begins a new scan.
REQ-007 Mode  input  1  0 = track minimum, 1 = track maximum; sampled only with an accepted Start.
REQ-008 In_Valid  input  1  scan beat present on In_Data/In_Addr.
REQ-009 In_Data  input  DATA_W  unsigned word under comparison.
REQ-010 In_Addr  input  ADDR_W  address associated with In_Data.
REQ-011 In_Last  input  1  marks the final beat of the scan; meaningful only with In_Valid.
REQ-012 In_Ready  output  1  block accepts beats; a beat is accepted when In_Valid and In_Ready are both high.
REQ-013 Busy  output  1  scan in progress.
REQ-014 Done  output  1  one-cycle pulse: results are final.
REQ-015 Best_Valid  output  1  Best_Data/Best_Addr hold at least one accepted beat of the current or last scan.
REQ-016 Best_Data  output  DATA_W  current extreme word.
REQ-017 Best_Addr  output  ADDR_W  address of Best_Data.
REQ-018 Beat_Count  output  ADDR_W+1  accepted beats in the current or last scan.

Function
REQ-019 FSM states IDLE, SCAN, DONE; the FSM is in IDLE after reset.
REQ-020 IDLE: In_Ready=0 and Busy=0; Start moves to SCAN, latches Mode, clears Beat_Count and Best_Valid, and holds Best_Data/Best_Addr.
REQ-021 SCAN: In_Ready=1 and Busy=1; Start is ignored.
REQ-022 The first accepted beat of a scan loads Best_Data/Best_Addr unconditionally and sets Best_Valid.
REQ-023 Each later accepted beat loads when In_Data is strictly less (Mode 0) or strictly greater (Mode 1) than Best_Data, unsigned.
REQ-024 An equal beat loads only when TIE_LAST=1.
REQ-025 Best_Data, Best_Addr and Beat_Count reflect an accepted beat on the cycle after acceptance (latency 1).
REQ-026 Beat_Count increments by 1 per accepted beat and saturates at 2^(ADDR_W+1)-1 without wrapping.
REQ-027 An accepted beat with In_Last=1 is compared like any other beat and moves the FSM to DONE.
REQ-028 In_Last without In_Valid has no effect.
REQ-029 DONE lasts exactly one cycle with Done=1, Busy=0 and In_Ready=0, then returns to IDLE.
REQ-030 Start asserted during DONE is ignored.
REQ-031 Results hold unchanged from DONE until the next accepted Start.
REQ-032 In_Valid outside SCAN is ignored; no output changes.
REQ-033 A Mode change outside an accepted Start has no effect on the running scan.
REQ-034 All outputs are registered.

Reset
REQ-035 Rst_n low asynchronously forces IDLE, Best_Data=0, Best_Addr=0, Beat_Count=0, Best_Valid=0, Done=0, Busy=0 and In_Ready=0, including mid-scan.
REQ-036 The first Start accepted after Rst_n deasserts begins a clean scan; no partial state from before reset survives.

Verification
REQ-037 Mode 0, beats (A0,D9),(A1,D3),(A2,D7,last) -> Done pulses one cycle after the A2 beat with Best_Data=3, Best_Addr=1, Beat_Count=3.
REQ-038 Mode 1, TIE_LAST=0, beats (A4,D5),(A5,D8),(A6,D8,last) -> Best_Data=8, Best_Addr=5; the same stimulus with TIE_LAST=1 -> Best_Addr=6.
REQ-039 In_Valid pulsed in IDLE with D0 and Start held high during SCAN -> outputs unchanged, no restart, and Beat_Count counts only SCAN beats.
REQ-040 Single beat (A7,D255,last) with Mode 0 -> Best_Data=255, Best_Addr=7, Beat_Count=1, Done one cycle later.
REQ-041 Rst_n pulled low after 2 of 4 beats -> all outputs 0 asynchronously; a new Start plus beats (A1,D2,last) -> Best_Data=2, Best_Addr=1, Beat_Count=1.
REQ-042 ADDR_W=2 with 9 accepted beats -> Beat_Count saturates at 7.
